// File: rtl/sequenciador_movimentos.sv
// Movement buffer and playback sequencer: stores a solution sequence in RAM and replays it to the servo manager.
// Optional single-step playback is compiled in with SEQ_PASSO_A_PASSO_EN.
module sequenciador_movimentos #(
  parameter int DEPTH   = 480,
  parameter int W_MOV   = 3,
  parameter int N_ADDR  = 9,
  parameter int COD_FIM = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              zera_s,
  input  logic              escreve,
  input  logic [W_MOV-1:0]  dado_movimento,
  input  logic              iniciar,
  input  logic              passo,
  input  logic              servo_pronto,
  output logic              aciona_servo,
  output logic [W_MOV-1:0]  movimento,
  output logic              movimento_par,
  output logic [N_ADDR-1:0] total,
  output logic [N_ADDR-1:0] executados,
  output logic              ocupado,
  output logic              pronto,
  output logic              cheio,
  output logic              erro_overflow,
  output logic [2:0]        db_estado
);

  localparam logic [W_MOV-1:0]  FIM_CODE = W_MOV'(COD_FIM);
  localparam logic [N_ADDR-1:0] DEPTH_C  = N_ADDR'(DEPTH);

  typedef enum logic [2:0] {
    OCIOSO  = 3'd0,
    LE      = 3'd1,
    CAPTURA = 3'd2,
    DISPARA = 3'd3,
    ESPERA  = 3'd4,
    AVANCA  = 3'd5,
    FIM     = 3'd6
  } estado_t;

  estado_t           estado, estado_nxt;
  logic [W_MOV-1:0]  mem [DEPTH];
  logic [W_MOV-1:0]  dado_ram_p1;
  logic [N_ADDR-1:0] read_addr;
  logic              escrita, wr_ok, avanca_ok;

  assign escrita   = (estado == OCIOSO) && escreve && !zera_s;
  assign wr_ok     = escrita && !cheio;
  assign cheio     = (total == DEPTH_C);
  assign db_estado = estado;

`ifdef SEQ_PASSO_A_PASSO_EN
  logic passo_visto;
  assign avanca_ok = passo_visto | passo;
`else
  // Free run: passo has no effect and folds away in synthesis.
  assign avanca_ok = passo | 1'b1;
`endif

  always_comb begin
    estado_nxt = estado;
    case (estado)
      OCIOSO:  if (iniciar) estado_nxt = (total == '0) ? FIM : LE;
      LE:      estado_nxt = CAPTURA;
      CAPTURA: estado_nxt = (dado_ram_p1 == FIM_CODE) ? FIM : DISPARA;
      DISPARA: estado_nxt = ESPERA;
      ESPERA:  if (servo_pronto) estado_nxt = AVANCA;
      AVANCA: begin
        if (read_addr == total) estado_nxt = FIM;
        else if (avanca_ok)     estado_nxt = LE;
      end
      FIM:     estado_nxt = OCIOSO;
      default: estado_nxt = OCIOSO;
    endcase
  end

  // Movement RAM: write port in OCIOSO, one-cycle registered read issued in LE
  always_ff @(posedge clock) begin
    if (wr_ok) mem[total] <= dado_movimento;
    if (estado == LE) dado_ram_p1 <= mem[read_addr];
  end

  // Control state, counters and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado        <= OCIOSO;
      total         <= '0;
      read_addr     <= '0;
      executados    <= '0;
      erro_overflow <= 1'b0;
      aciona_servo  <= 1'b0;
      pronto        <= 1'b0;
      ocupado       <= 1'b0;
      movimento     <= '0;
      movimento_par <= 1'b0;
`ifdef SEQ_PASSO_A_PASSO_EN
      passo_visto   <= 1'b0;
`endif
    end else if (zera_s) begin
      estado        <= OCIOSO;
      total         <= '0;
      read_addr     <= '0;
      executados    <= '0;
      erro_overflow <= 1'b0;
      aciona_servo  <= 1'b0;
      pronto        <= 1'b0;
      ocupado       <= 1'b0;
`ifdef SEQ_PASSO_A_PASSO_EN
      passo_visto   <= 1'b0;
`endif
    end else begin
      estado       <= estado_nxt;
      aciona_servo <= (estado_nxt == DISPARA);
      pronto       <= (estado_nxt == FIM);
      ocupado      <= (estado_nxt != OCIOSO);

      if (wr_ok) total <= total + 1'b1;
      if (escrita && cheio) erro_overflow <= 1'b1;

      if (estado == OCIOSO && iniciar) begin
        read_addr  <= '0;
        executados <= '0;
      end

      if (estado == CAPTURA) begin
        movimento     <= dado_ram_p1;
        movimento_par <= ~read_addr[0];
      end

      if (estado == ESPERA && servo_pronto) begin
        executados <= executados + 1'b1;
        read_addr  <= read_addr + 1'b1;
      end

`ifdef SEQ_PASSO_A_PASSO_EN
      // A step request is remembered from the last servo start until AVANCA consumes it
      if (estado == DISPARA || (estado == AVANCA && estado_nxt != AVANCA))
        passo_visto <= 1'b0;
      else if (passo)
        passo_visto <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_sequenciador_movimentos.sv
// Directed bench for sequenciador_movimentos (small DEPTH so the full-buffer case stays short).
module tb_sequenciador_movimentos;

  localparam int DEPTH  = 15;
  localparam int W_MOV  = 3;
  localparam int N_ADDR = 4;

  logic              clock = 1'b0;
  logic              reset, zera_s, escreve, iniciar, passo, servo_pronto;
  logic [W_MOV-1:0]  dado_movimento;
  logic              aciona_servo, movimento_par, ocupado, pronto, cheio, erro_overflow;
  logic [W_MOV-1:0]  movimento;
  logic [N_ADDR-1:0] total, executados;
  logic [2:0]        db_estado;

  int checks   = 0;
  int failures = 0;
  logic [W_MOV-1:0] seq_log [64];
  logic             par_log [64];
  int               t_log   [64];

  sequenciador_movimentos #(.DEPTH(DEPTH), .W_MOV(W_MOV), .N_ADDR(N_ADDR), .COD_FIM(0)) dut (
    .clock(clock), .reset(reset), .zera_s(zera_s), .escreve(escreve),
    .dado_movimento(dado_movimento), .iniciar(iniciar), .passo(passo),
    .servo_pronto(servo_pronto), .aciona_servo(aciona_servo), .movimento(movimento),
    .movimento_par(movimento_par), .total(total), .executados(executados),
    .ocupado(ocupado), .pronto(pronto), .cheio(cheio), .erro_overflow(erro_overflow),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic escreve_mov(input logic [W_MOV-1:0] c);
    escreve = 1'b1; dado_movimento = c; tick; escreve = 1'b0;
  endtask

  task automatic limpa;
    zera_s = 1'b1; tick; zera_s = 1'b0;
  endtask

  task automatic inicia;
    iniciar = 1'b1; tick; iniciar = 1'b0;
  endtask

  // Servo model: answers servo_pronto for one cycle, 'atraso' cycles after each start pulse
  task automatic play(input int atraso, input int limite, output int n, output bit fim);
    int w;
    n = 0; fim = 1'b0; w = 0;
    for (int c = 0; c < limite && !fim; c++) begin
      tick;
      servo_pronto = 1'b0;
      if (aciona_servo) begin
        if (n < 64) begin seq_log[n] = movimento; par_log[n] = movimento_par; t_log[n] = c; end
        n++;
        w = atraso;
      end else if (w > 0) begin
        w--;
        if (w == 0) servo_pronto = 1'b1;
      end
      if (pronto) fim = 1'b1;
    end
    servo_pronto = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; zera_s = 0; escreve = 0; iniciar = 0; passo = 0; servo_pronto = 0;
    dado_movimento = '0;
    #12;
    checks++;
    if ({aciona_servo, movimento, movimento_par, total, executados, ocupado, pronto,
         cheio, erro_overflow, db_estado} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0", {aciona_servo, movimento, movimento_par, total,
               executados, ocupado, pronto, cheio, erro_overflow, db_estado});
    end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_sequencia;
    int n; bit fim;
    escreve_mov(3'd1); escreve_mov(3'd2); escreve_mov(3'd3); escreve_mov(3'd0);
    checks++; if (total !== 4'd4) begin failures++; $display("FAIL seq_total_written got=%0d exp=4", total); end
    inicia;
    checks++; if (db_estado !== 3'd1) begin failures++; $display("FAIL seq_state_le got=%0d exp=1", db_estado); end
    play(5, 300, n, fim);
    checks++; if (fim !== 1'b1) begin failures++; $display("FAIL seq_pronto got=%0d exp=1", fim); end
    checks++; if (n !== 3) begin failures++; $display("FAIL seq_pulses got=%0d exp=3", n); end
    checks++; if (seq_log[0] !== 3'd1) begin failures++; $display("FAIL seq_mov0 got=%0d exp=1", seq_log[0]); end
    checks++; if (seq_log[1] !== 3'd2) begin failures++; $display("FAIL seq_mov1 got=%0d exp=2", seq_log[1]); end
    checks++; if (seq_log[2] !== 3'd3) begin failures++; $display("FAIL seq_mov2 got=%0d exp=3", seq_log[2]); end
    checks++; if (par_log[0] !== 1'b1 || par_log[1] !== 1'b0) begin
      failures++; $display("FAIL seq_par got=%b%b exp=10", par_log[0], par_log[1]);
    end
    checks++; if (t_log[0] !== 1) begin failures++; $display("FAIL seq_start_latency got=%0d exp=1", t_log[0]); end
    checks++; if (t_log[1] - t_log[0] !== 9) begin
      failures++; $display("FAIL seq_gap got=%0d exp=9", t_log[1] - t_log[0]);
    end
    checks++; if (executados !== 4'd3) begin failures++; $display("FAIL seq_executados got=%0d exp=3", executados); end
    checks++; if (total !== 4'd4) begin failures++; $display("FAIL seq_total got=%0d exp=4", total); end
    tick;
    checks++; if (pronto !== 1'b0 || ocupado !== 1'b0) begin
      failures++; $display("FAIL seq_after_fim got=%b%b exp=00", pronto, ocupado);
    end
  endtask

  task automatic test_vazio;
    limpa;
    checks++; if (total !== 4'd0) begin failures++; $display("FAIL vazio_total got=%0d exp=0", total); end
    inicia;
    checks++; if (pronto !== 1'b1 || aciona_servo !== 1'b0 || db_estado !== 3'd6) begin
      failures++; $display("FAIL vazio_fim got=%b%b%0d exp=106", pronto, aciona_servo, db_estado);
    end
    tick;
    checks++; if (pronto !== 1'b0 || db_estado !== 3'd0) begin
      failures++; $display("FAIL vazio_idle got=%b%0d exp=00", pronto, db_estado);
    end
  endtask

  task automatic test_cheio;
    int n; bit fim;
    limpa;
    for (int i = 0; i < DEPTH; i++) escreve_mov(3'd5);
    checks++; if (cheio !== 1'b1 || erro_overflow !== 1'b0 || total !== 4'(DEPTH)) begin
      failures++; $display("FAIL cheio_full got=%b%b%0d exp=1015", cheio, erro_overflow, total);
    end
    escreve_mov(3'd5);
    checks++; if (erro_overflow !== 1'b1 || total !== 4'(DEPTH)) begin
      failures++; $display("FAIL cheio_overflow got=%b%0d exp=115", erro_overflow, total);
    end
    inicia;
    play(1, 1000, n, fim);
    checks++; if (fim !== 1'b1 || n !== DEPTH) begin
      failures++; $display("FAIL cheio_play got=%0d,%0d exp=1,15", fim, n);
    end
    checks++; if (executados !== 4'(DEPTH)) begin
      failures++; $display("FAIL cheio_executados got=%0d exp=15", executados);
    end
    checks++; if (seq_log[DEPTH-1] !== 3'd5) begin
      failures++; $display("FAIL cheio_last_mov got=%0d exp=5", seq_log[DEPTH-1]);
    end
  endtask

  task automatic test_zera_espera;
    int n; int w; bit saw;
    limpa;
    checks++; if (erro_overflow !== 1'b0) begin failures++; $display("FAIL zera_clears_erro got=%b exp=0", erro_overflow); end
    escreve_mov(3'd1); escreve_mov(3'd2); escreve_mov(3'd3);
    inicia;
    n = 0; w = 0;
    for (int c = 0; c < 60 && n < 2; c++) begin
      tick;
      servo_pronto = 1'b0;
      if (aciona_servo) n++;
      if (n == 1) begin
        w++;
        if (w == 3) servo_pronto = 1'b1;
      end
    end
    servo_pronto = 1'b0;
    checks++; if (n !== 2) begin failures++; $display("FAIL zera_second_pulse got=%0d exp=2", n); end
    tick;
    escreve = 1'b1; dado_movimento = 3'd7; tick; escreve = 1'b0;
    checks++; if (total !== 4'd3 || erro_overflow !== 1'b0 || db_estado !== 3'd4) begin
      failures++; $display("FAIL zera_write_ignored got=%0d,%b,%0d exp=3,0,4", total, erro_overflow, db_estado);
    end
    limpa;
    checks++; if (ocupado !== 1'b0 || total !== 4'd0 || executados !== 4'd0 || db_estado !== 3'd0) begin
      failures++; $display("FAIL zera_clear got=%b,%0d,%0d,%0d exp=0,0,0,0", ocupado, total, executados, db_estado);
    end
    saw = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick;
      if (pronto || aciona_servo) saw = 1'b1;
    end
    checks++; if (saw !== 1'b0) begin failures++; $display("FAIL zera_no_pronto got=%b exp=0", saw); end
  endtask

  task automatic test_reset_disparo;
    limpa;
    escreve_mov(3'd2); escreve_mov(3'd3);
    inicia;
    tick; tick;
    checks++; if (aciona_servo !== 1'b1) begin failures++; $display("FAIL rst_disparo_setup got=%b exp=1", aciona_servo); end
    #2 reset = 1'b1;
    #1;
    checks++; if (aciona_servo !== 1'b0 || total !== 4'd0 || ocupado !== 1'b0 || db_estado !== 3'd0) begin
      failures++; $display("FAIL rst_async got=%b,%0d,%b,%0d exp=0,0,0,0", aciona_servo, total, ocupado, db_estado);
    end
    reset = 1'b0;
    tick;
  endtask

`ifdef SEQ_PASSO_A_PASSO_EN
  task automatic test_passo;
    bit got; int stuck; bit extra;
    limpa;
    escreve_mov(3'd1); escreve_mov(3'd2); escreve_mov(3'd3);
    inicia;
    got = 1'b0;
    for (int c = 0; c < 6 && !got; c++) begin
      tick;
      if (aciona_servo) got = 1'b1;
    end
    checks++; if (got !== 1'b1) begin failures++; $display("FAIL passo_first_pulse got=%b exp=1", got); end
    tick;
    servo_pronto = 1'b1; tick; servo_pronto = 1'b0;
    stuck = 0; extra = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick;
      if (db_estado !== 3'd5) stuck++;
      if (aciona_servo) extra = 1'b1;
    end
    checks++; if (stuck !== 0 || extra !== 1'b0) begin
      failures++; $display("FAIL passo_hold got=%0d,%b exp=0,0", stuck, extra);
    end
    passo = 1'b1; tick; passo = 1'b0;
    tick; tick;
    checks++; if (aciona_servo !== 1'b1 || movimento !== 3'd2) begin
      failures++; $display("FAIL passo_release got=%b,%0d exp=1,2", aciona_servo, movimento);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_sequencia;
    test_vazio;
    test_cheio;
    test_zera_espera;
    test_reset_disparo;
`ifdef SEQ_PASSO_A_PASSO_EN
    test_passo;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
